// File: rtl/qspi_mem_responder.sv
// Quad-SPI memory responder: byte-wide RAM behind a quad read/write command set.
// All QSPI inputs are oversampled in the clk_i domain. The sck edges are detected
// after synchronization, and every bus action is taken in response to a detected edge.
module qspi_mem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned DUMMY     = 4,
   parameter logic [7:0]  CMD_READ  = 8'hEB,
   parameter logic [7:0]  CMD_WRITE = 8'h38
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_in,
   input  logic       sck_i,
   input  logic [3:0] sd_i,
   output logic [3:0] sd_o,
   output logic [3:0] sd_oen_o,
   output logic       busy_o
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [3:0]  DummyLast = (DUMMY == 0) ? 4'd0 : 4'(DUMMY - 1);

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      cs_sync_q, cs_sync_d;    // [1] is synchronized, [2] is previous
   logic [2:0]      sck_sync_q, sck_sync_d;
   logic [3:0]      sd_s1_q, sd_s1_d;
   logic [3:0]      sd_s2_q, sd_s2_d;
   logic [1:0]      settle_q, settle_d;
   logic [3:0]      nib_q, nib_d;
   logic [3:0]      op_q, op_d;
   logic            is_wr_q, is_wr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [3:0]      hold_q, hold_d;
   logic [3:0]      sd_q, sd_d;
   logic [3:0]      oen_q, oen_d;

   logic [7:0]      mem [DEPTH];
   logic            mem_we;
   logic [7:0]      mem_wdata;
   logic [7:0]      rd_byte;
   logic            edge_en, cs_fall, cs_rise, sck_rise, sck_fall;
   logic [3:0]      sd_s;
   logic [7:0]      opcode;

   // Synchronizer shift and settle counter; edges stay masked until all three
   // stages hold real samples, so a bus already active at reset release is ignored
   always_comb begin
      cs_sync_d  = {cs_sync_q[1:0], cs_in};
      sck_sync_d = {sck_sync_q[1:0], sck_i};
      sd_s1_d    = sd_i;
      sd_s2_d    = sd_s1_q;
      settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
   end

   // Edge detection; sck edges only count while cs is low, which also gives a
   // coincident cs rising edge priority over any sck edge
   always_comb begin
      edge_en  = (settle_q == 2'd3);
      sd_s     = sd_s2_q;
      cs_fall  = edge_en & cs_sync_q[2] & ~cs_sync_q[1];
      cs_rise  = edge_en & ~cs_sync_q[2] & cs_sync_q[1];
      sck_rise = edge_en & ~cs_sync_q[1] & sck_sync_q[1] & ~sck_sync_q[2];
      sck_fall = edge_en & ~cs_sync_q[1] & ~sck_sync_q[1] & sck_sync_q[2];
      opcode   = {op_q, sd_s};
      rd_byte  = mem[ptr_q];
   end

   // Transaction FSM: next state, counters, pointer and output drive
   always_comb begin
      state_d   = state_q;
      nib_d     = nib_q;
      op_d      = op_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      sd_d      = sd_q;
      oen_d     = oen_q;
      mem_we    = 1'b0;
      mem_wdata = {hold_q, sd_s};
      if (cs_rise && (state_q != StIdle)) begin
         // Any held half-byte is simply dropped
         state_d = StIdle;
         nib_d   = 4'd0;
         oen_d   = 4'hF;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cs_fall) begin
                  state_d = StCmd;
                  nib_d   = 4'd0;
                  op_d    = 4'd0;
               end
            end
            StCmd: begin
               if (sck_rise) begin
                  op_d  = sd_s;
                  nib_d = nib_q + 4'd1;
                  if (nib_q[0]) begin
                     nib_d   = 4'd0;
                     is_wr_d = (opcode == CMD_WRITE);
                     state_d = ((opcode == CMD_READ) || (opcode == CMD_WRITE)) ? StAddr
                                                                                : StIgnore;
                  end
               end
            end
            StAddr: begin
               if (sck_rise) begin
                  // Only the low AW address bits are kept; upper nibbles shift out
                  addr_d = AW'({addr_q, sd_s});
                  nib_d  = nib_q + 4'd1;
                  if (nib_q == 4'd5) begin
                     nib_d = 4'd0;
                     ptr_d = AW'({addr_q, sd_s});
                     if (is_wr_q)         state_d = StWdata;
                     else if (DUMMY == 0) state_d = StRdata;
                     else                 state_d = StDummy;
                  end
               end
            end
            StDummy: begin
               if (sck_rise) begin
                  nib_d = nib_q + 4'd1;
                  if (nib_q == DummyLast) begin
                     nib_d   = 4'd0;
                     state_d = StRdata;
                  end
               end
            end
            StRdata: begin
               if (sck_fall) begin
                  oen_d = 4'h0;
                  sd_d  = nib_q[0] ? rd_byte[3:0] : rd_byte[7:4];
                  nib_d = {3'd0, ~nib_q[0]};
                  if (nib_q[0]) ptr_d = ptr_q + 1'b1;
               end
            end
            StWdata: begin
               if (sck_rise) begin
                  if (!nib_q[0]) begin
                     hold_d = sd_s;
                     nib_d  = 4'd1;
                  end else begin
                     mem_we = 1'b1;
                     ptr_d  = ptr_q + 1'b1;
                     nib_d  = 4'd0;
                  end
               end
            end
            StIgnore: begin
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and synchronizer registers; synchronizers reset to bus-idle levels
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cs_sync_q  <= 3'b111;
         sck_sync_q <= 3'b000;
         sd_s1_q    <= 4'd0;
         sd_s2_q    <= 4'd0;
         settle_q   <= 2'd0;
         nib_q      <= 4'd0;
         op_q       <= 4'd0;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         ptr_q      <= '0;
         hold_q     <= 4'd0;
         sd_q       <= 4'd0;
         oen_q      <= 4'hF;
      end else begin
         state_q    <= state_d;
         cs_sync_q  <= cs_sync_d;
         sck_sync_q <= sck_sync_d;
         sd_s1_q    <= sd_s1_d;
         sd_s2_q    <= sd_s2_d;
         settle_q   <= settle_d;
         nib_q      <= nib_d;
         op_q       <= op_d;
         is_wr_q    <= is_wr_d;
         addr_q     <= addr_d;
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         sd_q       <= sd_d;
         oen_q      <= oen_d;
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[ptr_q] <= mem_wdata;
   end

   assign sd_o     = sd_q;
   assign sd_oen_o = oen_q;
   assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: a QSPI initiator model driving sck at
// one quarter of clk_i with a random clock phase offset.
`timescale 1ns/1ns
module tb_qspi_mem_responder;

   logic       clk_i;
   logic       rst_i;
   logic       cs_in;
   logic       sck_i;
   logic [3:0] sd_i;
   logic [3:0] sd_o;
   logic [3:0] sd_oen_o;
   logic       busy_o;

   logic [3:0] tx [64];
   logic [3:0] rx [64];
   logic [3:0] oe [64];
   int         n_checks;
   int         n_fail;
   int         clk_phase;

   qspi_mem_responder #(
      .DEPTH     (1024),
      .DUMMY     (4),
      .CMD_READ  (8'hEB),
      .CMD_WRITE (8'h38)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .cs_in    (cs_in),
      .sck_i    (sck_i),
      .sd_i     (sd_i),
      .sd_o     (sd_o),
      .sd_oen_o (sd_oen_o),
      .busy_o   (busy_o)
   );

   // 10 ns clock; edges never land on the 5 ns stimulus grid
   initial begin
      int v;
      v = $urandom_range(1, 8);
      clk_phase = (v < 5) ? v : v + 1;
      clk_i = 1'b0;
      #(clk_phase);
      forever begin
         clk_i = 1'b1;
         #5;
         clk_i = 1'b0;
         #5;
      end
   end

   task automatic set_hdr(input logic [7:0] op, input logic [23:0] addr);
      for (int i = 0; i < 64; i++) tx[i] = 4'h0;
      tx[0] = op[7:4];
      tx[1] = op[3:0];
      for (int i = 0; i < 6; i++) tx[2 + i] = addr[23 - 4 * i -: 4];
   endtask

   // One 40 ns sck period: drive, rise, capture late in the high phase, fall
   task automatic sck_cycles(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         sd_i  = tx[i];
         #20 sck_i = 1'b1;
         #15 rx[i] = sd_o;
         oe[i] = sd_oen_o;
         #5 sck_i = 1'b0;
      end
   endtask

   task automatic run_xfer(input int n);
      cs_in = 1'b0;
      #40;
      sck_cycles(0, n);
      #20;
   endtask

   task automatic cs_release();
      cs_in = 1'b1;
      sd_i  = 4'h0;
      #40;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      cs_in = 1'b1;
      sck_i = 1'b0;
      sd_i  = 4'h0;
      #25;
      n_checks++;
      if (sd_oen_o !== 4'hF) begin n_fail++; $display("FAIL rst_oen: got %h want F", sd_oen_o); end
      n_checks++;
      if (sd_o !== 4'h0) begin n_fail++; $display("FAIL rst_sd_o: got %h want 0", sd_o); end
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end
      #25 rst_i = 1'b0;
      #50;
      // sck activity with cs high must not open a transaction
      for (int i = 0; i < 64; i++) tx[i] = 4'h3;
      sck_cycles(0, 4);
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL sck_cs_high_busy: got %b want 0", busy_o); end
   endtask

   task automatic test_write_read();
      logic [3:0] exp [4];
      exp = '{4'hA, 4'h5, 4'h3, 4'hC};
      set_hdr(8'h38, 24'h000010);
      tx[8] = 4'hA; tx[9] = 4'h5; tx[10] = 4'h3; tx[11] = 4'hC;
      run_xfer(12);
      n_checks++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wr_busy_open: got %b want 1", busy_o); end
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (oe[i] !== 4'hF) begin n_fail++; $display("FAIL wr_oen[%0d]: got %h want F", i, oe[i]); end
      end
      cs_release();
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wr_busy_closed: got %b want 0", busy_o); end
      set_hdr(8'hEB, 24'h000010);
      run_xfer(16);
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (oe[i] !== ((i >= 12) ? 4'h0 : 4'hF)) begin
            n_fail++;
            $display("FAIL rd_oen[%0d]: got %h want %h", i, oe[i], (i >= 12) ? 4'h0 : 4'hF);
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rx[12 + i] !== exp[i]) begin
            n_fail++;
            $display("FAIL rd_data[%0d]: got %h want %h", i, rx[12 + i], exp[i]);
         end
      end
      cs_release();
      n_checks++;
      if (sd_oen_o !== 4'hF) begin n_fail++; $display("FAIL rd_oen_release: got %h want F", sd_oen_o); end
   endtask

   task automatic test_wrap();
      logic [3:0] exp [4];
      exp = '{4'h1, 4'h1, 4'h2, 4'h2};
      set_hdr(8'h38, 24'h0003FF);
      tx[8] = 4'h1; tx[9] = 4'h1; tx[10] = 4'h2; tx[11] = 4'h2;
      run_xfer(12);
      cs_release();
      set_hdr(8'hEB, 24'h0003FF);
      run_xfer(16);
      cs_release();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rx[12 + i] !== exp[i]) begin
            n_fail++;
            $display("FAIL wrap_rd[%0d]: got %h want %h", i, rx[12 + i], exp[i]);
         end
      end
      set_hdr(8'hEB, 24'h000000);
      run_xfer(14);
      cs_release();
      n_checks++;
      if ({rx[12], rx[13]} !== 8'h22) begin
         n_fail++;
         $display("FAIL wrap_mem0: got %h want 22", {rx[12], rx[13]});
      end
   endtask

   task automatic test_ignore();
      for (int i = 0; i < 64; i++) tx[i] = 4'hF;
      tx[0] = 4'h9; tx[1] = 4'hF;
      tx[2] = 4'h3; tx[3] = 4'h8; tx[8] = 4'h1; tx[9] = 4'h0;
      run_xfer(22);
      for (int i = 0; i < 22; i++) begin
         n_checks++;
         if (oe[i] !== 4'hF) begin n_fail++; $display("FAIL ign_oen[%0d]: got %h want F", i, oe[i]); end
      end
      n_checks++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ign_busy_open: got %b want 1", busy_o); end
      cs_release();
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_busy_closed: got %b want 0", busy_o); end
      set_hdr(8'hEB, 24'h000010);
      run_xfer(16);
      cs_release();
      n_checks++;
      if ({rx[12], rx[13], rx[14], rx[15]} !== 16'hA53C) begin
         n_fail++;
         $display("FAIL ign_mem: got %h want A53C", {rx[12], rx[13], rx[14], rx[15]});
      end
   endtask

   task automatic test_partial_write();
      set_hdr(8'h38, 24'h000020);
      tx[10] = 4'h7; tx[11] = 4'h7;
      run_xfer(12);
      cs_release();
      set_hdr(8'h38, 24'h000020);
      tx[8] = 4'h1; tx[9] = 4'h2; tx[10] = 4'h3;
      run_xfer(11);
      // 40 ns after cs rises spans four clk_i rising edges
      cs_release();
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL part_busy: got %b want 0", busy_o); end
      set_hdr(8'hEB, 24'h000020);
      run_xfer(16);
      cs_release();
      n_checks++;
      if ({rx[12], rx[13]} !== 8'h12) begin
         n_fail++;
         $display("FAIL part_mem20: got %h want 12", {rx[12], rx[13]});
      end
      n_checks++;
      if ({rx[14], rx[15]} !== 8'h77) begin
         n_fail++;
         $display("FAIL part_mem21: got %h want 77", {rx[14], rx[15]});
      end
   endtask

   task automatic test_reset_abort();
      set_hdr(8'hEB, 24'h000010);
      cs_in = 1'b0;
      #40;
      sck_cycles(0, 14);
      n_checks++;
      if (rx[12] !== 4'hA) begin n_fail++; $display("FAIL abort_pre_data: got %h want A", rx[12]); end
      #10 rst_i = 1'b1;
      #5;
      n_checks++;
      if (sd_oen_o !== 4'hF) begin n_fail++; $display("FAIL abort_oen: got %h want F", sd_oen_o); end
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_o); end
      #20 rst_i = 1'b0;
      #40;
      // cs is still low: the remainder of this transaction must be ignored
      for (int i = 0; i < 64; i++) tx[i] = 4'hE;
      sck_cycles(0, 6);
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_stale_busy: got %b want 0", busy_o); end
      n_checks++;
      if (sd_oen_o !== 4'hF) begin n_fail++; $display("FAIL abort_stale_oen: got %h want F", sd_oen_o); end
      cs_release();
      set_hdr(8'hEB, 24'h000010);
      run_xfer(16);
      cs_release();
      n_checks++;
      if ({rx[12], rx[13], rx[14], rx[15]} !== 16'hA53C) begin
         n_fail++;
         $display("FAIL abort_next_rd: got %h want A53C", {rx[12], rx[13], rx[14], rx[15]});
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_write_read();
      test_wrap();
      test_ignore();
      test_partial_write();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
